// File: rtl/seguidor_linea_diferencial.sv
// Line-follower motor controller: synchronised/debounced sensor bar, differential steering,
// timed pivot search and a sticky lost-line state driving an L298-style dual H-bridge.
module seguidor_linea_diferencial #(
  parameter int unsigned N_SENSORES      = 3,
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned VEL_RECTA       = 200,
  parameter int unsigned VEL_GIRO        = 120,
  parameter int unsigned VEL_BUSQUEDA    = 90,
  parameter int unsigned DEBOUNCE_CICLOS = 4,
  parameter int unsigned TIEMPO_BUSQUEDA = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  habilitar,
  input  logic [N_SENSORES-1:0] sensores,
  output logic                  ENA,
  output logic                  IN1,
  output logic                  IN2,
  output logic                  ENB,
  output logic                  IN3,
  output logic                  IN4,
  output logic [2:0]            estado,
  output logic                  linea_perdida
);

  localparam int unsigned Centro = N_SENSORES / 2;
  localparam int unsigned CntW   = $clog2(N_SENSORES + 1);
  localparam int unsigned DebW   = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int unsigned TmrW   = $clog2(TIEMPO_BUSQUEDA + 1);
  localparam int unsigned VelMax = 2 ** PWM_BITS;

  if ((N_SENSORES % 2) == 0 || N_SENSORES < 3) begin : g_err_sensores
    $fatal(1, "N_SENSORES must be odd and >= 3");
  end
  if (VEL_RECTA >= VelMax || VEL_GIRO >= VelMax || VEL_BUSQUEDA >= VelMax) begin : g_err_vel
    $fatal(1, "speed parameters must be below 2**PWM_BITS");
  end
  if (DEBOUNCE_CICLOS < 1 || TIEMPO_BUSQUEDA < 1) begin : g_err_tiempos
    $fatal(1, "DEBOUNCE_CICLOS and TIEMPO_BUSQUEDA must be >= 1");
  end

  typedef enum logic [2:0] {
    StParado   = 3'd0,
    StRecto    = 3'd1,
    StGiroIzq  = 3'd2,
    StGiroDer  = 3'd3,
    StBusqueda = 3'd4,
    StPerdido  = 3'd5
  } estado_e;

  typedef enum logic [1:0] {ClsNinguna, ClsCentro, ClsIzq, ClsDer} clase_e;

  logic [N_SENSORES-1:0] sync1_q, sync2_q, deb_q;
  estado_e               state_q, state_d;
  logic [TmrW-1:0]       timer_q, timer_d;
  logic                  last_izq_q, last_izq_d;
  clase_e                clase;
  estado_e               linea_st;
  logic [CntW-1:0]       cnt_izq, cnt_der;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensores;
      sync2_q <= sync1_q;
    end
  end

  // A bit flips only after DEBOUNCE_CICLOS consecutive samples disagreeing with it.
  for (genvar g = 0; g < N_SENSORES; g++) begin : g_deb
    logic [DebW-1:0] cnt_q;
    logic            bit_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        bit_q <= 1'b0;
      end else if (sync2_q[g] == bit_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DebW'(DEBOUNCE_CICLOS - 1)) begin
        bit_q <= sync2_q[g];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DebW'(1);
      end
    end
    assign deb_q[g] = bit_q;
  end

  always_comb begin
    cnt_izq = '0;
    cnt_der = '0;
    for (int i = 0; i < int'(N_SENSORES); i++) begin
      if (i > int'(Centro)) begin
        cnt_izq = cnt_izq + CntW'(deb_q[i]);
      end else if (i < int'(Centro)) begin
        cnt_der = cnt_der + CntW'(deb_q[i]);
      end
    end
    if (deb_q == '0) begin
      clase = ClsNinguna;
    end else if (deb_q[Centro] || cnt_izq == cnt_der) begin
      clase = ClsCentro;
    end else if (cnt_izq > cnt_der) begin
      clase = ClsIzq;
    end else begin
      clase = ClsDer;
    end
  end

  always_comb begin
    unique case (clase)
      ClsCentro: linea_st = StRecto;
      ClsIzq:    linea_st = StGiroIzq;
      ClsDer:    linea_st = StGiroDer;
      default:   linea_st = StBusqueda;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!habilitar) begin
      state_d = StParado;
    end else begin
      case (state_q)
        StParado, StRecto, StGiroIzq, StGiroDer: state_d = linea_st;
        // A line seen on the timeout cycle takes priority over giving up.
        StBusqueda: begin
          if (clase != ClsNinguna) begin
            state_d = linea_st;
          end else if (timer_q == TmrW'(TIEMPO_BUSQUEDA - 1)) begin
            state_d = StPerdido;
          end
        end
        StPerdido: state_d = StPerdido;
        default:   state_d = StParado;
      endcase
    end
    timer_d    = (state_q == StBusqueda && state_d == StBusqueda) ? timer_q + TmrW'(1) : '0;
    last_izq_d = last_izq_q;
    if (clase == ClsIzq) begin
      last_izq_d = 1'b1;
    end else if (clase == ClsDer) begin
      last_izq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StParado;
      timer_q    <= '0;
      last_izq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_izq_q <= last_izq_d;
    end
  end

  // Motor command; direction encoding {INa, INb}: 10 fwd, 01 rev, 00 brake.
  logic [PWM_BITS-1:0] duty_izq_cmd, duty_der_cmd;
  logic [1:0]          dir_izq_cmd, dir_der_cmd;

  always_comb begin
    duty_izq_cmd = '0;
    duty_der_cmd = '0;
    dir_izq_cmd  = 2'b00;
    dir_der_cmd  = 2'b00;
    case (state_q)
      StRecto: begin
        duty_izq_cmd = PWM_BITS'(VEL_RECTA);
        duty_der_cmd = PWM_BITS'(VEL_RECTA);
        dir_izq_cmd  = 2'b10;
        dir_der_cmd  = 2'b10;
      end
      StGiroIzq: begin
        duty_izq_cmd = PWM_BITS'(VEL_GIRO);
        duty_der_cmd = PWM_BITS'(VEL_RECTA);
        dir_izq_cmd  = 2'b10;
        dir_der_cmd  = 2'b10;
      end
      StGiroDer: begin
        duty_izq_cmd = PWM_BITS'(VEL_RECTA);
        duty_der_cmd = PWM_BITS'(VEL_GIRO);
        dir_izq_cmd  = 2'b10;
        dir_der_cmd  = 2'b10;
      end
      StBusqueda: begin
        duty_izq_cmd = PWM_BITS'(VEL_BUSQUEDA);
        duty_der_cmd = PWM_BITS'(VEL_BUSQUEDA);
        dir_izq_cmd  = last_izq_q ? 2'b01 : 2'b10;
        dir_der_cmd  = last_izq_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_izq_q, duty_izq_d, duty_der_q, duty_der_d;
  logic [1:0]          dir_izq_q, dir_izq_d, dir_der_q, dir_der_d;
  logic                ena_q, ena_d, enb_q, enb_d;
  logic                forzar;

  // Disable and lost-line entry kill the bridge immediately instead of waiting for the wrap.
  assign forzar = !habilitar || state_d == StPerdido;

  always_comb begin
    cnt_d      = cnt_q + PWM_BITS'(1);
    duty_izq_d = duty_izq_q;
    duty_der_d = duty_der_q;
    dir_izq_d  = dir_izq_q;
    dir_der_d  = dir_der_q;
    if (forzar) begin
      duty_izq_d = '0;
      duty_der_d = '0;
      dir_izq_d  = 2'b00;
      dir_der_d  = 2'b00;
    end else if (cnt_q == '1) begin
      duty_izq_d = duty_izq_cmd;
      duty_der_d = duty_der_cmd;
      dir_izq_d  = dir_izq_cmd;
      dir_der_d  = dir_der_cmd;
    end
    ena_d = cnt_d < duty_izq_d;
    enb_d = cnt_d < duty_der_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      duty_izq_q <= '0;
      duty_der_q <= '0;
      dir_izq_q  <= 2'b00;
      dir_der_q  <= 2'b00;
      ena_q      <= 1'b0;
      enb_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_izq_q <= duty_izq_d;
      duty_der_q <= duty_der_d;
      dir_izq_q  <= dir_izq_d;
      dir_der_q  <= dir_der_d;
      ena_q      <= ena_d;
      enb_q      <= enb_d;
    end
  end

  assign ENA           = ena_q;
  assign ENB           = enb_q;
  assign IN1           = dir_izq_q[1];
  assign IN2           = dir_izq_q[0];
  assign IN3           = dir_der_q[1];
  assign IN4           = dir_der_q[0];
  assign estado        = state_q;
  assign linea_perdida = (state_q == StPerdido);

endmodule

// File: tb/tb_seguidor_linea_diferencial.sv
// Bench for seguidor_linea_diferencial: directed scenarios plus random sensor/enable traffic,
// every cycle compared against a behavioural model of the controller.
module tb_seguidor_linea_diferencial;

  localparam int N   = 3;
  localparam int PB  = 4;
  localparam int VR  = 12;
  localparam int VG  = 6;
  localparam int VB  = 4;
  localparam int DEB = 2;
  localparam int TB  = 40;
  localparam int PER = 2 ** PB;

  logic         clk = 1'b0;
  logic         reset, habilitar;
  logic [N-1:0] sensores;
  logic         ENA, IN1, IN2, ENB, IN3, IN4, linea_perdida;
  logic [2:0]   estado;

  int checks = 0;
  int failures = 0;

  seguidor_linea_diferencial #(
    .N_SENSORES(N), .PWM_BITS(PB), .VEL_RECTA(VR), .VEL_GIRO(VG), .VEL_BUSQUEDA(VB),
    .DEBOUNCE_CICLOS(DEB), .TIEMPO_BUSQUEDA(TB)
  ) dut (
    .clk(clk), .reset(reset), .habilitar(habilitar), .sensores(sensores),
    .ENA(ENA), .IN1(IN1), .IN2(IN2), .ENB(ENB), .IN3(IN3), .IN4(IN4),
    .estado(estado), .linea_perdida(linea_perdida)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [N-1:0] m_pipe[$];
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_s2, m_deb;
  int           m_st, m_busq, m_phase, m_dl, m_dr;
  bit           m_last_izq;
  logic [1:0]   m_dirl, m_dirr;
  logic         m_ena, m_enb;

  // Line state for a debounced pattern: 1 centre, 2 left, 3 right, 4 none.
  function automatic int clasifica(input logic [N-1:0] s);
    int l = 0;
    int r = 0;
    if (s == '0) return 4;
    for (int b = 0; b < N; b++) begin
      if (b > N / 2) l += int'(s[b]);
      else if (b < N / 2) r += int'(s[b]);
    end
    if (s[N/2] || l == r) return 1;
    if (l > r) return 2;
    return 3;
  endfunction

  task automatic comando(input int st, input bit li, output int dl, output int dr,
                         output logic [1:0] dirl, output logic [1:0] dirr);
    dl = 0; dr = 0; dirl = 2'b00; dirr = 2'b00;
    if (st == 1) begin dl = VR; dr = VR; dirl = 2'b10; dirr = 2'b10; end
    if (st == 2) begin dl = VG; dr = VR; dirl = 2'b10; dirr = 2'b10; end
    if (st == 3) begin dl = VR; dr = VG; dirl = 2'b10; dirr = 2'b10; end
    if (st == 4) begin
      dl = VB; dr = VB;
      dirl = li ? 2'b01 : 2'b10;
      dirr = li ? 2'b10 : 2'b01;
    end
  endtask

  task automatic model_edge(input logic h, input logic [N-1:0] s, input logic r);
    int cls, nst, dl, dr;
    logic [1:0] dirl, dirr;
    bit todos;
    if (r) begin
      m_pipe.delete(); m_pipe.push_back('0);
      m_hist.delete();
      m_s2 = '0; m_deb = '0; m_st = 0; m_busq = 0; m_phase = 0; m_last_izq = 0;
      m_dl = 0; m_dr = 0; m_dirl = 2'b00; m_dirr = 2'b00; m_ena = 0; m_enb = 0;
      return;
    end
    cls = clasifica(m_deb);
    if (!h) nst = 0;
    else if (m_st <= 3) nst = cls;
    else if (m_st == 4) nst = (cls != 4) ? cls : ((m_busq + 1 >= TB) ? 5 : 4);
    else nst = 5;
    if (m_phase == PER - 1) begin
      comando(m_st, m_last_izq, dl, dr, dirl, dirr);
      m_dl = dl; m_dr = dr; m_dirl = dirl; m_dirr = dirr;
    end
    if (!h || nst == 5) begin
      m_dl = 0; m_dr = 0; m_dirl = 2'b00; m_dirr = 2'b00;
    end
    m_phase = (m_phase + 1) % PER;
    m_ena = (m_phase < m_dl);
    m_enb = (m_phase < m_dr);
    m_busq = (m_st == 4 && nst == 4) ? m_busq + 1 : 0;
    if (cls == 2) m_last_izq = 1;
    if (cls == 3) m_last_izq = 0;
    m_st = nst;
    // Debounce: a bit takes the synced value once the last DEB samples all agree.
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB) begin
      for (int b = 0; b < N; b++) begin
        todos = 1;
        for (int j = 1; j < DEB; j++) if (m_hist[j][b] != m_hist[0][b]) todos = 0;
        if (todos) m_deb[b] = m_hist[0][b];
      end
    end
    m_pipe.push_back(s);
    m_s2 = m_pipe.pop_front();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic h, input logic [N-1:0] s, input logic r);
    habilitar = h; sensores = s; reset = r;
    @(posedge clk);
    model_edge(h, s, r);
    #1;
    chk("estado", 32'(estado), 32'(m_st));
    chk("linea_perdida", 32'(linea_perdida), 32'(m_st == 5));
    chk("motor", 32'({ENA, IN1, IN2, ENB, IN3, IN4}), 32'({m_ena, m_dirl, m_enb, m_dirr}));
  endtask

  task automatic run_count(input logic [N-1:0] s, input int n, output int ca, output int cb);
    ca = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, s, 1'b0);
      ca += int'(ENA);
      cb += int'(ENB);
    end
  endtask

  initial begin
    int ca, cb, n, hold;
    bit h, r;
    logic [N-1:0] cur;

    // Reset
    step(1'b0, 3'b000, 1'b1);
    step(1'b0, 3'b000, 1'b1);
    chk("reset_estado", 32'(estado), 32'd0);
    chk("reset_pins", 32'({ENA, IN1, IN2, ENB, IN3, IN4, linea_perdida}), 32'd0);

    // T1: centred line -> RECTO after 5 clk, 12/16 duty both forward
    for (int i = 0; i < 5; i++) step(1'b1, 3'b010, 1'b0);
    chk("t1_estado_5clk", 32'(estado), 32'd1);
    for (int i = 0; i < 11; i++) step(1'b1, 3'b010, 1'b0);
    run_count(3'b010, PER, ca, cb);
    chk("t1_duty_ena", 32'(ca), 32'd12);
    chk("t1_duty_enb", 32'(cb), 32'd12);
    chk("t1_dir", 32'({IN1, IN2, IN3, IN4}), 32'b1010);

    // T2: left sensor -> GIRO_IZQ, inner (left) wheel slowed
    for (int i = 0; i < 32; i++) step(1'b1, 3'b100, 1'b0);
    chk("t2_estado", 32'(estado), 32'd2);
    run_count(3'b100, PER, ca, cb);
    chk("t2_duty_ena", 32'(ca), 32'd6);
    chk("t2_duty_enb", 32'(cb), 32'd12);

    // T3: one-cycle glitch rejected by debounce
    for (int i = 0; i < 40; i++) step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b010, 1'b0);
      chk("t3_glitch", 32'(estado), 32'd1);
    end

    // T4: lose line after a left turn -> pivot left for TB clk, then PERDIDO
    for (int i = 0; i < 10; i++) step(1'b1, 3'b100, 1'b0);
    n = 0;
    for (int i = 0; i < 120; i++) begin
      step(1'b1, 3'b000, 1'b0);
      if (estado == 3'd4) begin
        n++;
        if (n == 20) chk("t4_pivot_dir", 32'({IN1, IN2, IN3, IN4}), 32'b0110);
      end
      if (estado == 3'd5) break;
    end
    chk("t4_busqueda_len", 32'(n), 32'(TB));
    chk("t4_perdido", 32'({estado, linea_perdida}), 32'b1011);
    chk("t4_en_off", 32'({ENA, ENB}), 32'd0);

    // T5: PERDIDO is sticky until habilitar drops
    for (int i = 0; i < 10; i++) step(1'b1, 3'b010, 1'b0);
    chk("t5_sticky", 32'(estado), 32'd5);
    step(1'b0, 3'b010, 1'b0);
    chk("t5_parado", 32'(estado), 32'd0);
    step(1'b1, 3'b010, 1'b0);
    chk("t5_recto", 32'(estado), 32'd1);

    // T6: disable mid-period, then reset mid-search
    for (int i = 0; i < 20; i++) step(1'b1, 3'b010, 1'b0);
    for (int i = 0; i < 2 * PER && m_phase != 3; i++) step(1'b1, 3'b010, 1'b0);
    chk("t6_phase_found", 32'(m_phase), 32'd3);
    chk("t6_ena_pre", 32'(ENA), 32'd1);
    step(1'b0, 3'b010, 1'b0);
    chk("t6_disable_pins", 32'({ENA, IN1, IN2, ENB, IN3, IN4}), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 3'b000, 1'b0);
    chk("t6_in_busqueda", 32'(estado), 32'd4);
    step(1'b1, 3'b000, 1'b1);
    chk("t6_reset_pins", 32'({ENA, IN1, IN2, ENB, IN3, IN4, linea_perdida, estado}), 32'd0);

    // Random traffic
    hold = 0;
    cur = '0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        cur = N'($urandom_range(0, 2 ** N - 1));
        hold = $urandom_range(1, 60);
      end
      hold--;
      h = ($urandom_range(0, 31) != 0);
      r = ($urandom_range(0, 299) == 0);
      step(h, cur, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
